program_counter_stack: RTL and testbench

//   Parametrised SAP program counter with jump load, call/return stack, halt freeze and bus output.

---
 rtl/program_counter_stack.sv | 111 +++++++++++
 tb/tb_program_counter_stack.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_counter_stack.sv
// rtl/program_counter_stack.sv - SAP program counter with jump load, call/return stack, halt freeze and W-bus output.
module program_counter_stack #(
    parameter int              WIDTH      = 4,
    parameter int              DEPTH      = 4,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_hlt,
    input  logic             i_inc,
    input  logic             i_ld,
    input  logic             i_call,
    input  logic             i_ret,
    input  logic [WIDTH-1:0] i_ld_addr,
    input  logic             i_oe,
    output logic [WIDTH-1:0] o_bus_out,
    output logic [WIDTH-1:0] o_pc,
    output logic             o_stk_empty,
    output logic             o_stk_full,
    output logic             o_wrap,
    output logic             o_err
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SPW-1:0] FULL_SP = SPW'(DEPTH);

    logic [WIDTH-1:0] r_pc;
    logic [SPW-1:0]   r_sp;
    logic [WIDTH-1:0] r_stack [DEPTH];
    logic             r_stk_empty;
    logic             r_stk_full;
    logic             r_wrap;
    logic             r_err;

    logic [WIDTH-1:0] w_pc_inc;
    logic [SPW-1:0]   w_sp_dec;
    logic [IW-1:0]    w_push_idx;
    logic [IW-1:0]    w_pop_idx;
    logic [WIDTH-1:0] w_pc_next;
    logic [SPW-1:0]   w_sp_next;
    logic             w_push;
    logic             w_err_next;
    logic             w_wrap_next;

    assign w_pc_inc   = r_pc + 1'b1;
    assign w_sp_dec   = r_sp - 1'b1;
    // Indices are only used when the push/pop is legal, so truncation never aliases.
    assign w_push_idx = r_sp[IW-1:0];
    assign w_pop_idx  = w_sp_dec[IW-1:0];

    always_comb begin
        w_pc_next   = r_pc;
        w_sp_next   = r_sp;
        w_push      = 1'b0;
        w_err_next  = r_err;
        w_wrap_next = 1'b0;
        if (i_hlt) begin
            w_pc_next = r_pc;
        end else if (i_ret) begin
            if (r_sp == '0) begin
                w_err_next = 1'b1;
            end else begin
                w_sp_next = w_sp_dec;
                w_pc_next = r_stack[w_pop_idx];
            end
        end else if (i_call) begin
            if (r_sp == FULL_SP) begin
                w_err_next = 1'b1;
            end else begin
                w_push    = 1'b1;
                w_sp_next = r_sp + 1'b1;
                w_pc_next = i_ld_addr;
            end
        end else if (i_ld) begin
            w_pc_next = i_ld_addr;
        end else if (i_inc) begin
            w_pc_next   = w_pc_inc;
            w_wrap_next = (r_pc == '1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_pc        <= RESET_ADDR;
            r_sp        <= '0;
            r_stk_empty <= 1'b1;
            r_stk_full  <= 1'b0;
            r_wrap      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_pc        <= w_pc_next;
            r_sp        <= w_sp_next;
            r_stk_empty <= (w_sp_next == '0);
            r_stk_full  <= (w_sp_next == FULL_SP);
            r_wrap      <= w_wrap_next;
            r_err       <= w_err_next;
            if (w_push) begin
                r_stack[w_push_idx] <= w_pc_inc;
            end
        end
    end

    assign o_bus_out   = i_oe ? r_pc : {WIDTH{1'bz}};
    assign o_pc        = r_pc;
    assign o_stk_empty = r_stk_empty;
    assign o_stk_full  = r_stk_full;
    assign o_wrap      = r_wrap;
    assign o_err       = r_err;

endmodule

// File: tb/tb_program_counter_stack.sv
// tb/tb_program_counter_stack.sv - self-checking bench for program_counter_stack with a queue-based reference model.
module tb_program_counter_stack;

    localparam int W     = 4;
    localparam int D     = 4;
    localparam int RADDR = 0;
    localparam int MOD   = 1 << W;

    logic         clk = 1'b0;
    logic         clr = 1'b0, hlt = 1'b0, inc = 1'b0, ld = 1'b0, call = 1'b0, ret = 1'b0, oe = 1'b0;
    logic [W-1:0] ld_addr = '0;
    wire  [W-1:0] bus_out;
    logic [W-1:0] pc;
    logic         stk_empty, stk_full, wrap, err;

    int n_checks = 0;
    int n_errors = 0;

    int m_pc = RADDR;
    int m_q[$];
    bit m_err = 1'b0;
    bit m_wrap = 1'b0;

    program_counter_stack #(.WIDTH(W), .DEPTH(D), .RESET_ADDR(W'(RADDR))) dut (
        .i_clk(clk), .i_clr(clr), .i_hlt(hlt), .i_inc(inc), .i_ld(ld), .i_call(call),
        .i_ret(ret), .i_ld_addr(ld_addr), .i_oe(oe), .o_bus_out(bus_out), .o_pc(pc),
        .o_stk_empty(stk_empty), .o_stk_full(stk_full), .o_wrap(wrap), .o_err(err)
    );

    always #5 clk = ~clk;

    // Drives one cycle of inputs, advances the model at the edge, returns at the next falling edge.
    task automatic cycle(input bit c, input bit h, input bit i, input bit l, input bit ca,
                         input bit r, input int addr, input bit o);
        clr = c; hlt = h; inc = i; ld = l; call = ca; ret = r; ld_addr = W'(addr); oe = o;
        @(posedge clk);
        if (c) begin
            m_pc = RADDR; m_q.delete(); m_err = 0; m_wrap = 0;
        end else begin
            m_wrap = 0;
            if (h) begin
            end else if (r) begin
                if (m_q.size() == 0) m_err = 1;
                else m_pc = m_q.pop_back();
            end else if (ca) begin
                if (m_q.size() == D) m_err = 1;
                else begin
                    m_q.push_back((m_pc + 1) % MOD);
                    m_pc = addr % MOD;
                end
            end else if (l) begin
                m_pc = addr % MOD;
            end else if (i) begin
                m_wrap = (m_pc == MOD - 1);
                m_pc = (m_pc + 1) % MOD;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        n_checks++;
        if (pc !== W'(RADDR) || stk_empty !== 1'b1 || stk_full !== 1'b0 || wrap !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: pc=%0d empty=%b full=%b wrap=%b err=%b, want pc=%0d 1 0 0 0",
                     pc, stk_empty, stk_full, wrap, err, RADDR);
        end
    endtask

    task automatic test_inc_wrap;
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            cycle(0, 0, 1, 0, 0, 0, 0, 0);
            n_checks++;
            if (pc !== W'((k + 1) % 16) || wrap !== (k == 15)) begin
                n_errors++;
                $display("FAIL inc_wrap[%0d]: pc=%0d wrap=%b, want pc=%0d wrap=%b",
                         k, pc, wrap, (k + 1) % 16, (k == 15));
            end
        end
    endtask

    task automatic test_ld;
        cycle(0, 0, 0, 1, 0, 0, 3, 0);
        cycle(0, 0, 1, 1, 0, 0, 9, 0);
        n_checks++;
        if (pc !== 4'd9 || stk_empty !== 1'b1) begin
            n_errors++;
            $display("FAIL ld_over_inc: pc=%0d empty=%b, want pc=9 empty=1", pc, stk_empty);
        end
    endtask

    task automatic test_call_ret;
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 5, 0);
        cycle(0, 0, 0, 0, 1, 0, 12, 0);
        n_checks++;
        if (pc !== 4'd12 || stk_empty !== 1'b0) begin
            n_errors++;
            $display("FAIL call: pc=%0d empty=%b, want pc=12 empty=0", pc, stk_empty);
        end
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        n_checks++;
        if (pc !== 4'd6 || stk_empty !== 1'b1 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL ret: pc=%0d empty=%b err=%b, want pc=6 empty=1 err=0", pc, stk_empty, err);
        end
    endtask

    task automatic test_overflow;
        int exp_ret[4] = '{11, 7, 3, 1};
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 1, 0, 4 * k + 2, 0);
        n_checks++;
        if (pc !== 4'd14 || stk_full !== 1'b1 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL four_calls: pc=%0d full=%b err=%b, want pc=14 full=1 err=0", pc, stk_full, err);
        end
        cycle(0, 0, 0, 0, 1, 0, 0, 0);
        n_checks++;
        if (pc !== 4'd14 || stk_full !== 1'b1 || err !== 1'b1) begin
            n_errors++;
            $display("FAIL call_full: pc=%0d full=%b err=%b, want pc=14 full=1 err=1", pc, stk_full, err);
        end
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 0, 0, 1, 0, 0);
            n_checks++;
            if (pc !== W'(exp_ret[k]) || stk_full !== 1'b0 || err !== 1'b1) begin
                n_errors++;
                $display("FAIL unwind[%0d]: pc=%0d full=%b err=%b, want pc=%0d full=0 err=1",
                         k, pc, stk_full, err, exp_ret[k]);
            end
        end
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        n_checks++;
        if (pc !== 4'd1 || stk_empty !== 1'b1 || err !== 1'b1) begin
            n_errors++;
            $display("FAIL ret_empty: pc=%0d empty=%b err=%b, want pc=1 empty=1 err=1", pc, stk_empty, err);
        end
    endtask

    task automatic test_hlt_oe;
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 7, 0);
        for (int k = 0; k < 8; k++) begin
            cycle(0, 1, 1, k[0], k[1], k[2], 13, k[0]);
            n_checks++;
            if (pc !== 4'd7 || stk_empty !== 1'b0 || err !== 1'b0 || wrap !== 1'b0) begin
                n_errors++;
                $display("FAIL hlt[%0d]: pc=%0d empty=%b err=%b wrap=%b, want pc=7 empty=0 err=0 wrap=0",
                         k, pc, stk_empty, err, wrap);
            end
            n_checks++;
            if (bus_out !== (k[0] ? 4'd7 : 4'bzzzz)) begin
                n_errors++;
                $display("FAIL hlt_bus[%0d]: bus_out=%b, want %b", k, bus_out, k[0] ? 4'd7 : 4'bzzzz);
            end
        end
    endtask

    task automatic test_clr_with_ret;
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 4, 0);
        cycle(0, 0, 0, 0, 1, 0, 8, 0);
        n_checks++;
        if (err !== 1'b1 || stk_empty !== 1'b0) begin
            n_errors++;
            $display("FAIL pre_clr: err=%b empty=%b, want err=1 empty=0", err, stk_empty);
        end
        cycle(1, 0, 0, 0, 0, 1, 0, 0);
        n_checks++;
        if (pc !== W'(RADDR) || stk_empty !== 1'b1 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL clr_ret: pc=%0d empty=%b err=%b, want pc=%0d empty=1 err=0",
                     pc, stk_empty, err, RADDR);
        end
    endtask

    task automatic test_random;
        bit c, h, i, l, ca, r, o;
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 400; k++) begin
            c  = ($urandom_range(0, 49) == 0);
            h  = ($urandom_range(0, 9) == 0);
            i  = $urandom_range(0, 1);
            l  = ($urandom_range(0, 4) == 0);
            ca = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 3) == 0);
            o  = $urandom_range(0, 1);
            cycle(c, h, i, l, ca, r, $urandom_range(0, MOD - 1), o);
            n_checks++;
            if (pc !== W'(m_pc) || stk_empty !== (m_q.size() == 0) || stk_full !== (m_q.size() == D)
                || wrap !== m_wrap || err !== m_err) begin
                n_errors++;
                $display("FAIL random[%0d]: pc=%0d empty=%b full=%b wrap=%b err=%b, want pc=%0d empty=%b full=%b wrap=%b err=%b",
                         k, pc, stk_empty, stk_full, wrap, err, m_pc, (m_q.size() == 0),
                         (m_q.size() == D), m_wrap, m_err);
            end
            n_checks++;
            if (bus_out !== (o ? W'(m_pc) : {W{1'bz}})) begin
                n_errors++;
                $display("FAIL random_bus[%0d]: bus_out=%b oe=%b, want pc=%0d", k, bus_out, o, m_pc);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_inc_wrap();
        test_ld();
        test_call_ret();
        test_overflow();
        test_hlt_oe();
        test_clr_with_ret();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
